// File: rtl/key_event_pkg.sv
// Shared constants and types for the key event scheduler.
package key_event_pkg;

   localparam int unsigned KEY_NUM = 4;
   localparam int unsigned EV_W    = 4;

   localparam logic [1:0] EV_PRESS   = 2'b00;
   localparam logic [1:0] EV_LONG    = 2'b01;
   localparam logic [1:0] EV_REPEAT  = 2'b10;
   localparam logic [1:0] EV_RELEASE = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StHeld,
      StLong
   } key_state_e;

   function automatic logic [EV_W-1:0] ev_pack(logic [1:0] key_id, logic [1:0] ev_type);
      return {key_id, ev_type};
   endfunction

endpackage

// File: rtl/key_event_if.sv
// Valid/ready event stream between the key scheduler and its consumer.
interface key_event_if
   import key_event_pkg::*;
();
   logic            ev_valid;
   logic [EV_W-1:0] ev_data;
   logic            ev_ready;

   modport master (output ev_valid, output ev_data, input ev_ready);
   modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/key_event_fifo.sv
// Generic first-word-fall-through FIFO; dout reads zero while empty.
module key_event_fifo #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0]    wr_q, rd_q;
   logic [PW:0]      cnt_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (PW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem_q[rd_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PW'(1);
         if (do_pop)  rd_q <= rd_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/key_event_ctrl.sv
// Turns four debounced active-low keys into PRESS/LONG/REPEAT/RELEASE events,
// arbitrates them by key index and queues them for a valid/ready consumer.
module key_event_ctrl
   import key_event_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 25000,
   parameter int unsigned LONG_MS    = 1000,
   parameter int unsigned REP_MS     = 200,
   parameter bit          REPEAT_EN  = 1'b1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [KEY_NUM-1:0] btn_db,
   key_event_if.master        ev,
   output logic               overflow,
   input  logic               ovf_clr
);
   localparam int unsigned PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PSW-1:0]     presc_q;
   logic               tick;
   logic [KEY_NUM-1:0] btn_prev_q;
   logic               arm_q;
   logic [KEY_NUM-1:0] emit;
   logic [1:0]         emit_t [KEY_NUM];
   logic [KEY_NUM-1:0] pend_v_q;
   logic [1:0]         pend_t_q [KEY_NUM];
   logic [KEY_NUM-1:0] grant;
   logic               push, fifo_full, fifo_empty, fifo_pop, can_push, drop;
   logic [EV_W-1:0]    push_data;
   logic               overflow_q;

   assign tick = (presc_q == PSW'(TICK_DIV - 1));

   // arm_q masks the first cycle after reset so keys held through reset give no PRESS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q    <= '0;
         btn_prev_q <= '1;
         arm_q      <= 1'b0;
      end else begin
         presc_q    <= tick ? '0 : presc_q + PSW'(1);
         btn_prev_q <= btn_db;
         arm_q      <= 1'b1;
      end
   end

   for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
      key_state_e  state_q, state_d;
      logic [10:0] hcnt_q, hcnt_d, hcnt_inc;
      logic        press, fire;
      logic [1:0]  fire_t;

      assign press    = arm_q & btn_prev_q[k] & ~btn_db[k];
      assign hcnt_inc = hcnt_q + 11'd1;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= StIdle;
            hcnt_q  <= '0;
         end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
         end
      end

      always_comb begin
         state_d = state_q;
         hcnt_d  = hcnt_q;
         case (state_q)
            StIdle: begin
               if (press) begin
                  state_d = StHeld;
                  hcnt_d  = '0;
               end
            end
            StHeld: begin
               if (btn_db[k]) begin
                  state_d = StIdle;
               end else if (tick) begin
                  if (hcnt_inc == 11'(LONG_MS)) begin
                     state_d = StLong;
                     hcnt_d  = '0;
                  end else begin
                     hcnt_d = hcnt_inc;
                  end
               end
            end
            StLong: begin
               if (btn_db[k]) begin
                  state_d = StIdle;
               end else if (tick && REPEAT_EN) begin
                  hcnt_d = (hcnt_inc == 11'(REP_MS)) ? '0 : hcnt_inc;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      // Release is checked first so it wins over LONG/REPEAT in the same cycle.
      always_comb begin
         fire   = 1'b0;
         fire_t = EV_PRESS;
         case (state_q)
            StIdle: fire = press;
            StHeld: begin
               if (btn_db[k]) begin
                  fire   = 1'b1;
                  fire_t = EV_RELEASE;
               end else if (tick && hcnt_inc == 11'(LONG_MS)) begin
                  fire   = 1'b1;
                  fire_t = EV_LONG;
               end
            end
            StLong: begin
               if (btn_db[k]) begin
                  fire   = 1'b1;
                  fire_t = EV_RELEASE;
               end else if (tick && REPEAT_EN && hcnt_inc == 11'(REP_MS)) begin
                  fire   = 1'b1;
                  fire_t = EV_REPEAT;
               end
            end
            default: fire = 1'b0;
         endcase
      end

      assign emit[k]   = fire;
      assign emit_t[k] = fire_t;
   end

   assign fifo_pop = ev.ev_valid & ev.ev_ready;
   assign can_push = ~fifo_full | fifo_pop;

   always_comb begin
      logic found;
      found     = 1'b0;
      grant     = '0;
      push_data = '0;
      for (int k = 0; k < KEY_NUM; k++) begin
         if (can_push && pend_v_q[k] && !found) begin
            found     = 1'b1;
            grant[k]  = 1'b1;
            push_data = ev_pack(2'(k), pend_t_q[k]);
         end
      end
   end

   assign push = |grant;
   // A slot is free for a new event if empty or being drained this cycle.
   assign drop = |(emit & pend_v_q & ~grant);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_v_q   <= '0;
         overflow_q <= 1'b0;
         for (int k = 0; k < KEY_NUM; k++) pend_t_q[k] <= '0;
      end else begin
         for (int k = 0; k < KEY_NUM; k++) begin
            if (emit[k]) begin
               if (!pend_v_q[k] || grant[k]) begin
                  pend_v_q[k] <= 1'b1;
                  pend_t_q[k] <= emit_t[k];
               end
            end else if (grant[k]) begin
               pend_v_q[k] <= 1'b0;
            end
         end
         if (drop)         overflow_q <= 1'b1;
         else if (ovf_clr) overflow_q <= 1'b0;
      end
   end

   assign overflow   = overflow_q;
   assign ev.ev_valid = ~fifo_empty;

   key_event_fifo #(
      .WIDTH (EV_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_data),
      .full  (fifo_full),
      .pop   (fifo_pop),
      .dout  (ev.ev_data),
      .empty (fifo_empty)
   );

endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Event scheduler that sits behind the 4-key debouncer and in front of the menu/control logic. It converts the four debounced, active-low key levels into discrete PRESS / LONG / REPEAT / RELEASE events. It arbitrates simultaneous events from the four keys and buffers them in a small FIFO. Consumers read the events through a valid/ready handshake.

## Interface
- TICK_DIV, 25_000: clk cycles per timing tick (1 ms at 25 MHz)
- LONG_MS, 1000: ticks a key must be held before LONG fires; range 2..2047
- REP_MS, 200: ticks between REPEAT events after LONG; range 1..2047
- REPEAT_EN, 1: 0 suppresses REPEAT events entirely
- FIFO_DEPTH, 4: event FIFO entries; power of two, minimum 2

- clk  in  1  system clock, single domain
- rst_n  in  1  asynchronous, active-low reset
- btn_db  in  4  debounced key levels; 1 = released (idle), 0 = pressed
- ev_valid  out  1  FIFO head holds an event
- ev_data  out  4  {key_id[1:0], ev_type[1:0]}; ev_type 00 PRESS, 01 LONG, 10 REPEAT, 11 RELEASE
- ev_ready  in  1  consumer accepts head when ev_valid & ev_ready
- overflow  out  1  sticky; an event was dropped
- ovf_clr  in  1  synchronous clear of overflow; set has priority over clear in the same cycle

## Operation
- Reset values:
  - btn_prev = 4'hF, so no spurious press is seen after reset.
  - All key FSMs IDLE, hold counters 0, prescaler 0, pending flags 0.
  - FIFO empty: ev_valid 0, ev_data 0, overflow 0.
- Prescaler: free-running 0..TICK_DIV-1. tick is a one-cycle pulse when the count wraps.
- Per-key FSM, with hold counter hcnt (11 bits):
  - IDLE: btn_prev=1 & btn_db=0 → emit PRESS, hcnt←0, go to HELD.
  - HELD: each tick increments hcnt. When hcnt reaches LONG_MS → emit LONG, hcnt←0, go to LONG.
  - LONG: if REPEAT_EN, each tick increments hcnt. When hcnt reaches REP_MS → emit REPEAT, hcnt←0.
  - HELD or LONG with btn_db=1: emit RELEASE, go to IDLE. RELEASE wins over LONG/REPEAT in the same cycle.
- Pending slots: each key has a one-entry pending register {valid, type}. An emitted event loads the slot.
  - If the slot is still valid when a new event arrives, the new event is dropped and overflow is set.
  - The pending event is never overwritten.
- Arbiter:
  - Each cycle, the lowest-index valid pending slot is granted, provided the FIFO can accept a push.
  - The FIFO can accept a push when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs in the same cycle.
  - The granted slot clears and its event is pushed.
  - A slot that is being granted may be reloaded in the same cycle.
  - At most one push per cycle.
- FIFO:
  - First-word-fall-through: ev_data shows the head whenever ev_valid=1.
  - ev_data holds its value while ev_valid=1 and ev_ready=0.
  - Pop on ev_valid & ev_ready.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is one bit wider.
- Key changes while a key is in IDLE with btn_db=0 (possible only after reset with a key held) produce no event until the key is released and pressed again.

## Timing
- The press edge is sampled at cycle N. The pending slot is valid at N+1, the FIFO push happens at the end of N+1, and ev_valid=1 from N+2. Latency is 2 cycles with an empty FIFO and no competing key.
- Four simultaneous PRESS events push on four consecutive cycles in key order 0,1,2,3. With an empty FIFO, ev_valid rises at N+2.
- LONG fires on the (LONG_MS)th tick after the press edge. Tick phase is not reset on press, so hold time jitters by up to 1 tick.
- ev_ready may be asserted before ev_valid. ev_valid does not depend combinationally on ev_ready.
- rst_n low mid-operation immediately empties the FIFO and returns all FSMs to IDLE. Keys held through reset generate no PRESS.

## Structure
- Package key_event_pkg contains:
  - the ev_type localparams (EV_PRESS, EV_LONG, EV_REPEAT, EV_RELEASE);
  - the key FSM state encoding (IDLE, HELD, LONG);
  - the KEY_NUM=4 constant.
- Sub-module key_event_fifo: a generic FWFT FIFO with parameters WIDTH and DEPTH, and ports push/din/full/pop/dout/empty. It lets the FIFO be reused by other event sources.
- The four per-key FSMs are a generate loop inside key_event_ctrl, not separate modules.

## Test plan
Use TICK_DIV=4, LONG_MS=5, REP_MS=3, FIFO_DEPTH=4 in simulation.
- Short press: press key2 for 10 cycles, then release → ev_data 4'b1000, then 4'b1011. ev_valid first rises 2 cycles after the press edge.
- Long hold with repeat: hold key1 for 60 cycles with ev_ready=1 → PRESS 4'b0100, LONG 4'b0101 after 5 ticks, REPEAT 4'b0110 every 3 ticks, then RELEASE 4'b0111.
- Simultaneous press: all keys pressed in the same cycle → events 0x0, 0x4, 0x8, 0xC on consecutive cycles, in that order.
- Overflow: ev_ready=0, press and release all four keys twice → the first 4 events are retained in order, overflow=1. Pulsing ovf_clr then returns overflow to 0.
- REPEAT_EN=0: hold key3 for 60 cycles → only 0xC, then 0xD, then 0xF on release.
- Reset: assert rst_n low with 2 events queued and key0 held → ev_valid=0 and overflow=0. After reset, no event appears until key0 is released and pressed again.
